// File: rtl/ctrl_botones_ajuste.sv
// Adjust-button front end: 2-FF sync, debounce, edit/field FSM, one-hot EN, up/down pulses with auto-repeat.
// Latency: raw press -> pulse in DEB_CYCLES+3 cycles; no backpressure, pulses are fire-and-forget.
module ctrl_botones_ajuste #(
  parameter int N_CAMPOS   = 6,
  parameter int CNT_W      = 27,
  parameter int DEB_CYCLES = 1000000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_set,
  output logic                edit,
  output logic [N_CAMPOS-1:0] EN,
  output logic                up,
  output logic                down
);

  localparam int PTR_W = (N_CAMPOS > 1) ? $clog2(N_CAMPOS) : 1;
  localparam int NB    = 5;
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_SET   = 4;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_DLY  = CNT_W'(REP_DELAY);
  localparam logic [CNT_W-1:0] REP_PER  = CNT_W'(REP_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CAMPOS - 1);
  localparam logic [N_CAMPOS-1:0] EN_ONE = {{(N_CAMPOS-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_EDIT} state_t;

  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    r_deb;
  logic [NB-1:0]    r_deb_d;
  logic [CNT_W-1:0] r_deb_cnt [NB];
  logic [NB-1:0]    w_press;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_edit;
  logic [N_CAMPOS-1:0] r_en;

  logic [CNT_W-1:0] r_rep_cnt [2];
  logic [1:0]       r_rep_ph;
  logic [1:0]       r_rep_act;
  logic [1:0]       w_hold;
  logic [1:0]       w_first;
  logic [1:0]       w_rep;
  logic             r_up;
  logic             r_down;

  assign w_raw   = {btn_set, btn_right, btn_left, btn_down, btn_up};
  assign w_press = r_deb & ~r_deb_d;
  assign w_edit  = (r_state == S_EDIT);

  // The debounced level only moves after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < NB; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_en    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_en    <= w_edit ? (EN_ONE << r_ptr) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_press[B_SET]) begin
          w_state_nxt = S_EDIT;
          w_ptr_nxt   = '0;
        end
      end
      S_EDIT: begin
        if (w_press[B_SET]) begin
          w_state_nxt = S_IDLE;
        end else if (w_press[B_RIGHT] && !w_press[B_LEFT]) begin
          w_ptr_nxt = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end else if (w_press[B_LEFT] && !w_press[B_RIGHT]) begin
          w_ptr_nxt = (r_ptr == '0) ? PTR_LAST : r_ptr - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A set press wins over a simultaneous up/down press and kills any pending repeat.
  always_comb begin
    w_hold[0]  = w_edit & r_deb[B_UP] & ~r_deb[B_DOWN] & ~w_press[B_SET];
    w_hold[1]  = w_edit & r_deb[B_DOWN] & ~r_deb[B_UP] & ~w_press[B_SET];
    w_first[0] = w_hold[0] & w_press[B_UP];
    w_first[1] = w_hold[1] & w_press[B_DOWN];
    for (int d = 0; d < 2; d++) begin
      w_rep[d] = w_hold[d] & r_rep_act[d] &
                 (r_rep_ph[d] ? (r_rep_cnt[d] == REP_PER) : (r_rep_cnt[d] == REP_DLY));
    end
  end

  // Repeat is armed only by a real press, so releasing one of a held pair stays silent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) r_rep_cnt[d] <= '0;
      r_rep_ph  <= '0;
      r_rep_act <= '0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!w_hold[d]) begin
          r_rep_cnt[d] <= '0;
          r_rep_ph[d]  <= 1'b0;
          r_rep_act[d] <= 1'b0;
        end else if (w_first[d]) begin
          r_rep_cnt[d] <= CNT_ONE;
          r_rep_ph[d]  <= 1'b0;
          r_rep_act[d] <= 1'b1;
        end else if (r_rep_act[d]) begin
          if (w_rep[d]) begin
            r_rep_cnt[d] <= CNT_ONE;
            r_rep_ph[d]  <= 1'b1;
          end else if (r_rep_cnt[d] != CNT_MAX) begin
            r_rep_cnt[d] <= r_rep_cnt[d] + 1'b1;
          end
        end
      end
      r_up   <= w_first[0] | w_rep[0];
      r_down <= w_first[1] | w_rep[1];
    end
  end

  assign edit = w_edit;
  assign EN   = r_en;
  assign up   = r_up;
  assign down = r_down;

endmodule
